// File: rtl/bl_order_decode.sv
// Receive-side baseline order decoder: canonical baseline address, frame counting.
// Optional duplicate/missing-baseline checking enabled by defining BL_DUP_CHECK_EN.
module bl_order_decode #(
    parameter int N_ANTS   = 8,
    parameter int FRM_BITS = 16,
    localparam int ANT_BITS = $clog2(N_ANTS),
    localparam int N_BLS    = N_ANTS * (N_ANTS + 1) / 2,
    localparam int BL_BITS  = $clog2(N_BLS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sync,
    input  logic                en,
    input  logic [ANT_BITS-1:0] ant_a,
    input  logic [ANT_BITS-1:0] ant_b,
    input  logic                buf_sel,
    output logic [BL_BITS-1:0]  bl_addr,
    output logic                bl_valid,
    output logic                bl_buf_sel,
    output logic                sync_out,
    output logic                frame_done,
    output logic [FRM_BITS-1:0] frame_cnt,
    output logic                dup_err,
    output logic                miss_err
);

    localparam logic [BL_BITS:0] CNT_ONE  = (BL_BITS+1)'(1);
    localparam logic [BL_BITS:0] CNT_LAST = (BL_BITS+1)'(N_BLS - 1);

    logic [BL_BITS:0]    cnt_reg, cnt_next;
    logic                last_next;
    logic [ANT_BITS-1:0] lo_in, hi_in;
    logic [ANT_BITS-1:0] s1_lo_reg, s1_hi_reg;
    logic                s1_en_reg, s1_sync_reg, s1_buf_reg, s1_last_reg;
    logic [BL_BITS:0]    hi_ext, tri_prod;
    logic [BL_BITS-1:0]  addr_s1;

    assign lo_in = (ant_a < ant_b) ? ant_a : ant_b;
    assign hi_in = (ant_a < ant_b) ? ant_b : ant_a;

    // sync restarts the count; a sample arriving with sync is index 0 of the new frame
    always_comb begin
        cnt_next  = cnt_reg;
        last_next = 1'b0;
        if (sync) begin
            cnt_next = en ? CNT_ONE : '0;
        end else if (en) begin
            if (cnt_reg == CNT_LAST) begin
                cnt_next  = '0;
                last_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= '0;
            s1_lo_reg   <= '0;
            s1_hi_reg   <= '0;
            s1_en_reg   <= 1'b0;
            s1_sync_reg <= 1'b0;
            s1_buf_reg  <= 1'b0;
            s1_last_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            s1_lo_reg   <= lo_in;
            s1_hi_reg   <= hi_in;
            s1_en_reg   <= en;
            s1_sync_reg <= sync;
            s1_buf_reg  <= buf_sel;
            s1_last_reg <= last_next;
        end
    end

    // hi*(hi+1) is always even and below 2*N_BLS, so BL_BITS+1 bits hold it exactly
    assign hi_ext   = {{(BL_BITS+1-ANT_BITS){1'b0}}, s1_hi_reg};
    assign tri_prod = hi_ext * (hi_ext + CNT_ONE);
    assign addr_s1  = tri_prod[BL_BITS:1] + {{(BL_BITS-ANT_BITS){1'b0}}, s1_lo_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            bl_addr    <= '0;
            bl_valid   <= 1'b0;
            bl_buf_sel <= 1'b0;
            sync_out   <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            bl_addr    <= addr_s1;
            bl_valid   <= s1_en_reg;
            bl_buf_sel <= s1_buf_reg;
            sync_out   <= s1_sync_reg;
            frame_done <= s1_last_reg;
            if (s1_last_reg) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

`ifdef BL_DUP_CHECK_EN
    logic [N_BLS-1:0] seen_reg;
    logic [N_BLS-1:0] addr_onehot, seen_base, seen_with;

    genvar gi;
    generate
        for (gi = 0; gi < N_BLS; gi++) begin : g_onehot
            assign addr_onehot[gi] = (addr_s1 == BL_BITS'(gi));
        end
    endgenerate

    // map is checked and updated at stage 2 so both flags line up with bl_valid
    always_comb begin
        seen_base = s1_sync_reg ? '0 : seen_reg;
        seen_with = seen_base | (s1_en_reg ? addr_onehot : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_reg <= '0;
            dup_err  <= 1'b0;
            miss_err <= 1'b0;
        end else begin
            if (s1_en_reg && ((seen_base & addr_onehot) != '0)) begin
                dup_err <= 1'b1;
            end
            if (s1_sync_reg && (seen_reg != '0) && !(&seen_reg)) begin
                miss_err <= 1'b1;
            end
            if (s1_last_reg && !(&seen_with)) begin
                miss_err <= 1'b1;
            end
            seen_reg <= s1_last_reg ? '0 : seen_with;
        end
    end
`else
    assign dup_err  = 1'b0;
    assign miss_err = 1'b0;
`endif

endmodule

// File: tb/tb_bl_order_decode.sv
// Self-checking bench for bl_order_decode (N_ANTS=8): directed and randomized frames
// compared cycle by cycle against a behavioural frame/baseline model.
module tb_bl_order_decode;

    localparam int N_ANTS = 8;
    localparam int N_BLS  = 36;

    logic        clk = 1'b0;
    logic        rst, sync, en, buf_sel;
    logic [2:0]  ant_a, ant_b;
    logic [5:0]  bl_addr;
    logic        bl_valid, bl_buf_sel, sync_out, frame_done, dup_err, miss_err;
    logic [15:0] frame_cnt;

    bl_order_decode #(.N_ANTS(N_ANTS), .FRM_BITS(16)) dut (
        .clk(clk), .rst(rst), .sync(sync), .en(en), .ant_a(ant_a), .ant_b(ant_b),
        .buf_sel(buf_sel), .bl_addr(bl_addr), .bl_valid(bl_valid), .bl_buf_sel(bl_buf_sel),
        .sync_out(sync_out), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .dup_err(dup_err), .miss_err(miss_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       valid;
        bit [5:0] addr;
        bit       bsel;
        bit       sync;
        bit       done;
        int       fcnt;
        bit       dup;
        bit       miss;
    } exp_t;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t pend;

    // reference model state: a frame is a set of baselines plus a sample count
    int m_count, m_fcnt, m_nseen;
    bit m_seen[N_BLS];
    bit m_dup, m_miss;
    int pa[N_BLS], pb[N_BLS];
    int ord[N_BLS];

    function automatic int ref_addr(input int a, input int b);
        int h, l, s;
        h = (a > b) ? a : b;
        l = (a > b) ? b : a;
        s = 0;
        for (int i = 1; i <= h; i++) s += i;
        return s + l;
    endfunction

    function automatic void clear_seen();
        for (int i = 0; i < N_BLS; i++) m_seen[i] = 0;
        m_nseen = 0;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit e, input int a, input int b);
        exp_t now_e, nxt;
        int   addr;
        rst = r; sync = s; en = e;
        ant_a = 3'(a); ant_b = 3'(b);
        buf_sel = 1'($urandom_range(0, 1));
        nxt = '{default: 0};
        if (r) begin
            m_count = 0; m_fcnt = 0; m_dup = 0; m_miss = 0;
            clear_seen();
        end else begin
            if (s) begin
                if (m_nseen > 0 && m_nseen < N_BLS) m_miss = 1;
                clear_seen();
                m_count = 0;
            end
            if (e) begin
                addr = ref_addr(a, b);
                if (m_seen[addr]) m_dup = 1;
                else m_nseen++;
                m_seen[addr] = 1;
                m_count++;
                nxt.valid = 1;
                nxt.addr  = 6'(addr);
                nxt.bsel  = buf_sel;
                if (m_count == N_BLS) begin
                    nxt.done = 1;
                    m_fcnt   = (m_fcnt + 1) % 65536;
                    if (m_nseen < N_BLS) m_miss = 1;
                    clear_seen();
                    m_count = 0;
                end
            end
            nxt.sync = s;
            nxt.fcnt = m_fcnt;
`ifdef BL_DUP_CHECK_EN
            nxt.dup  = m_dup;
            nxt.miss = m_miss;
`endif
        end
        @(posedge clk);
        #1;
        now_e = r ? '{default: 0} : pend;
        chk("bl_valid", int'(bl_valid), int'(now_e.valid));
        if (now_e.valid) begin
            chk("bl_addr", int'(bl_addr), int'(now_e.addr));
            chk("bl_buf_sel", int'(bl_buf_sel), int'(now_e.bsel));
        end
        chk("sync_out", int'(sync_out), int'(now_e.sync));
        chk("frame_done", int'(frame_done), int'(now_e.done));
        chk("frame_cnt", int'(frame_cnt), now_e.fcnt);
        chk("dup_err", int'(dup_err), int'(now_e.dup));
        chk("miss_err", int'(miss_err), int'(now_e.miss));
        pend = nxt;
    endtask

    task automatic send_frame(input bit sync_with_first, input int skip_idx, input int dup_idx);
        if (!sync_with_first) step(0, 1, 0, 0, 0);
        for (int i = 0; i < N_BLS; i++) begin
            if (i == skip_idx) step(0, sync_with_first && i == 0, 1, pa[dup_idx], pb[dup_idx]);
            else step(0, sync_with_first && i == 0, 1, pa[i], pb[i]);
        end
    endtask

    initial begin
        int k;
        pend = '{default: 0};
        m_count = 0; m_fcnt = 0; m_dup = 0; m_miss = 0;
        clear_seen();
        k = 0;
        for (int b = 0; b < N_ANTS; b++)
            for (int a = 0; a <= b; a++) begin
                pa[k] = a; pb[k] = b; k++;
            end

        // reset, then address mapping incl. swapped order
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 2, 3);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 3, 5);
        step(0, 0, 1, 5, 3);
        step(0, 0, 1, 7, 7);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // full frame after a lone sync, then 3 back-to-back frames with sync on the first sample
        send_frame(0, -1, 0);
        step(0, 0, 0, 0, 0);
        for (int f = 0; f < 3; f++) send_frame(1, -1, 0);
        step(0, 0, 0, 0, 0);

        // mid-frame sync discards a partial frame
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 1, pa[i], pb[i]);
        send_frame(0, -1, 0);
        step(0, 0, 0, 0, 0);

        // (2,4) sent twice in place of (1,1)
        step(1, 0, 0, 0, 0);
        send_frame(0, ref_addr(1, 1), ref_addr(2, 4));
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);

        // reset mid-stream with en, sync active
        step(0, 1, 1, 0, 0);
        for (int i = 1; i < 10; i++) step(0, 0, 1, pa[i], pb[i]);
        step(1, 1, 1, 6, 2);
        for (int i = 0; i < N_BLS; i++) step(0, 0, 1, pa[i], pb[i]);

        // randomized shuffled frames with gaps, swapped antennas and occasional duplicates
        step(1, 0, 0, 0, 0);
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N_BLS; i++) ord[i] = i;
            for (int i = 0; i < N_BLS - 1; i++) begin
                int j, t;
                j = $urandom_range(i, N_BLS - 1);
                t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
            if ($urandom_range(0, 2) == 0) ord[$urandom_range(0, N_BLS - 1)] = ord[0];
            step(0, 1, 0, 0, 0);
            for (int i = 0; i < N_BLS; i++) begin
                if ($urandom_range(0, 3) == 0) step(0, 0, 0, $urandom_range(0, 7), $urandom_range(0, 7));
                if ($urandom_range(0, 1) == 0) step(0, 0, 1, pa[ord[i]], pb[ord[i]]);
                else step(0, 0, 1, pb[ord[i]], pa[ord[i]]);
            end
        end

        // random noise with rare sync and rare reset
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 149) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7));
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/bl_order_decode.md
Name: bl_order_decode

Overview:
- Receive-side companion to the X-engine baseline order generator.
- Consumes the (ant_a, ant_b, buf_sel) stream qualified by en and framed by sync, in the order the generator emits it.
- Maps each antenna pair to a canonical linear baseline address for the accumulator/readout RAM.
- Counts baselines per frame, flags frame completion and tracks completed frames.

Parameters:
- N_ANTS, 8, number of antennas; a power of two ≥ 2.
- ANT_BITS, log2(N_ANTS), antenna index width; derived, do not override.
- N_BLS, N_ANTS*(N_ANTS+1)/2, baselines per frame, autos included; derived.
- BL_BITS, log2(N_BLS), baseline address width; derived (6 for N_ANTS=8).
- FRM_BITS, 16, width of the frame counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sync  in  1  one-cycle frame marker; the first baseline of a frame may arrive on the same cycle or on any later cycle.
- en  in  1  ant_a/ant_b/buf_sel are valid this cycle.
- ant_a  in  ANT_BITS  first antenna index.
- ant_b  in  ANT_BITS  second antenna index.
- buf_sel  in  1  generator buffer select; passed through.
- bl_addr  out  BL_BITS  canonical baseline address.
- bl_valid  out  1  bl_addr/bl_buf_sel are valid.
- bl_buf_sel  out  1  buf_sel delayed to align with bl_addr.
- sync_out  out  1  sync delayed to align with bl_addr.
- frame_done  out  1  one-cycle pulse with the last baseline of a frame.
- frame_cnt  out  FRM_BITS  frames completed since reset; wraps.
- dup_err  out  1  sticky duplicate-baseline flag (optional feature).
- miss_err  out  1  sticky missing-baseline flag (optional feature).

Behaviour:
- Reset: all outputs 0. Internal baseline counter 0. Pipeline valid bits cleared. rst overrides every other input on the same edge.
- Address mapping:
  - lo = min(ant_a, ant_b), hi = max(ant_a, ant_b).
  - bl_addr = hi*(hi+1)/2 + lo. Result is always < N_BLS; no wrap handling needed.
  - Order of ant_a/ant_b is irrelevant: (a,b) and (b,a) give the same address.
- Pipeline, fixed latency of 2 cycles:
  - Stage 1 registers lo, hi, en, sync, buf_sel.
  - Stage 2 registers bl_addr and the control bits.
  - bl_valid = en delayed 2. sync_out = sync delayed 2, independent of en.
  - No backpressure; accepts one input every cycle.
- Baseline counter (BL_BITS+1 bits), updated in stage 1:
  - sync clears the counter. If en is also high that cycle, the sample counts as index 0, leaving the counter at 1.
  - Otherwise, en increments the counter.
  - When the counter reaches N_BLS on an en, the stage-1 "last" bit is set and the counter returns to 0.
- frame_done: asserted with the bl_valid of that last sample. frame_cnt increments on the same edge and wraps at 2^FRM_BITS.
- Sync mid-frame: partial count discarded, no frame_done, frame_cnt unchanged. Samples already in the pipeline still emerge normally.
- en before the first sync after reset: decoded and output normally; counting starts from reset state 0.
- Reset mid-frame: pipeline contents dropped; no outputs on the following 2 cycles.

Optional Feature:
- Macro: BL_DUP_CHECK_EN.
- When defined:
  - Maintain an N_BLS-bit seen-map, cleared on rst, on sync, and after each frame_done.
  - An en whose address is already set in the map sets dup_err, aligned with that sample's bl_valid.
  - At frame_done, any clear bit after including the last address sets miss_err.
  - At sync mid-frame, any unseen bit sets miss_err, unless the map was empty (nothing received yet).
  - Both flags are sticky until rst.
- When undefined: no map is built; dup_err and miss_err are tied to 0.

Test Plan (N_ANTS=8):
- Mapping: rst for 2 cycles, then en with (0,0), (3,5), (5,3), (7,7) → bl_addr 0, 18, 18, 35 with bl_valid exactly 2 cycles after each input; bl_buf_sel matches the delayed buf_sel.
- Full frame: sync, then 36 consecutive en cycles over all pairs with a ≤ b → 36 bl_valid, frame_done once with the 36th, frame_cnt 0→1, both error flags 0.
- Back-to-back frames: sync+en on the same cycle, 3 frames of 36 with no gaps → 3 frame_done pulses spaced 36 cycles apart, frame_cnt = 3.
- Mid-frame sync: 20 baselines, sync, then 36 baselines → exactly one frame_done, on the 36th after the sync; frame_cnt = 1; miss_err = 1 only if BL_DUP_CHECK_EN is defined.
- Duplicate (macro defined): a frame with (2,4) sent twice and (1,1) omitted → dup_err rises 2 cycles after the second (2,4); miss_err rises at frame_done; both stay high until rst.
- Reset mid-stream: rst during en activity → all outputs 0 on the next edge; no bl_valid in the next 2 cycles; counter restarts from 0.
